fb_buffer_ctrl: RTL

//   Framebuffer buffer manager for N-buffered (2 or 3) bitmap rendering in the system clock domain.

---
 rtl/fb_pkg.sv | 25 ++
 rtl/fb_read_gen.sv | 72 +++++++
 rtl/fb_buffer_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared types and helpers for the framebuffer buffer manager.
package fb_pkg;

    typedef enum logic [2:0] {StIdle, StWait, StClear, StDraw, StDone} fb_state_e;

    localparam int unsigned MaxNbuf = 3;

    typedef logic [1:0] buf_idx_t;

    // Lowest buffer neither on display nor queued for display; returns nbuf when none is free.
    function automatic int unsigned pick_free(input int unsigned nbuf,
                                              input int unsigned disp_idx,
                                              input int unsigned ready_idx,
                                              input logic        ready_valid);
        int unsigned pick;
        pick = nbuf;
        for (int unsigned i = 0; i < MaxNbuf; i++) begin
            if (pick == nbuf && i < nbuf && i != disp_idx && !(ready_valid && i == ready_idx)) begin
                pick = i;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fb_read_gen.sv
// Display readout: framebuffer line/pixel counters driving the linebuffer input enable
// and the framebuffer read address.
module fb_read_gen
    import fb_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = 320,
    parameter int unsigned FB_HEIGHT = 180,
    parameter int unsigned FB_SCALE  = 2,
    parameter int unsigned ADDRW     = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame,
    input  logic             line,
    input  logic             line0,
    output logic             lb_en_in,
    output logic [ADDRW-1:0] fb_addr_read
);

    localparam int unsigned FbPix = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned LineW = (FB_SCALE > 1) ? $clog2(FB_SCALE) : 1;
    localparam int unsigned XW    = $clog2(FB_WIDTH + 1);
    localparam logic [ADDRW-1:0] LastAddr  = ADDRW'(FbPix - 1);
    localparam logic [LineW-1:0] LastScale = LineW'(FB_SCALE - 1);

    logic [LineW-1:0] cnt_lb_line_q;
    logic             lb_line_q;
    logic [XW-1:0]    cnt_lbx_q;
    logic [ADDRW-1:0] addr_q;
    logic             en;

    // Only the first display line of each scaled group loads the linebuffer.
    assign en = lb_line_q && (cnt_lb_line_q == '0) && (cnt_lbx_q < XW'(FB_WIDTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_lb_line_q <= '0;
            lb_line_q     <= 1'b0;
            cnt_lbx_q     <= '0;
            addr_q        <= '0;
        end else begin
            if (line0) begin
                cnt_lb_line_q <= '0;
            end else if (line) begin
                cnt_lb_line_q <= (cnt_lb_line_q == LastScale) ? '0 : cnt_lb_line_q + LineW'(1);
            end

            if (frame) begin
                lb_line_q <= 1'b0;
            end else if (line0) begin
                lb_line_q <= 1'b1;
            end

            if (line) begin
                cnt_lbx_q <= '0;
            end else if (en) begin
                cnt_lbx_q <= cnt_lbx_q + XW'(1);
            end

            // Frame restart wins; the address holds at the last pixel rather than running past it.
            if (frame) begin
                addr_q <= '0;
            end else if (en && addr_q != LastAddr) begin
                addr_q <= addr_q + ADDRW'(1);
            end
        end
    end

    assign lb_en_in     = en;
    assign fb_addr_read = addr_q;

endmodule

// File: rtl/fb_buffer_ctrl.sv
// N-buffered framebuffer manager: picks/clears the draw buffer, starts the renderer,
// publishes finished buffers at frame start and muxes writes into the framebuffers.
module fb_buffer_ctrl
    import fb_pkg::*;
#(
    parameter int unsigned NBUF      = 2,
    parameter int unsigned FB_WIDTH  = 320,
    parameter int unsigned FB_HEIGHT = 180,
    parameter int unsigned FB_SCALE  = 2,
    parameter int unsigned DATAW     = 4,
    parameter int unsigned ADDRW     = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame,
    input  logic                    line,
    input  logic                    line0,
    input  logic                    clear_en,
    input  logic [DATAW-1:0]        clear_colr,
    output logic                    render_start,
    input  logic                    render_done,
    input  logic                    draw_we,
    input  logic [ADDRW-1:0]        draw_addr,
    input  logic [DATAW-1:0]        draw_colr,
    output logic [NBUF-1:0]         fb_we,
    output logic [ADDRW-1:0]        fb_addr_write,
    output logic [DATAW-1:0]        fb_colr_write,
    output logic [ADDRW-1:0]        fb_addr_read,
    output logic [$clog2(NBUF)-1:0] fb_rsel,
    output logic                    lb_en_in,
    output logic                    busy,
    output logic [7:0]              cnt_drop
);

    localparam int unsigned IdxW  = $clog2(NBUF);
    localparam int unsigned FbPix = FB_WIDTH * FB_HEIGHT;
    localparam logic [ADDRW-1:0] LastAddr = ADDRW'(FbPix - 1);

    fb_state_e        state_q, state_d;
    logic [IdxW-1:0]  draw_idx_q, disp_idx_q, ready_idx_q, free_idx;
    logic             ready_valid_q, free_found, publish;
    logic [31:0]      free_sel;
    logic [DATAW-1:0] clr_colr_q;
    logic [ADDRW-1:0] clr_addr_q;
    logic [7:0]       cnt_drop_q;
    logic             render_start_q;
    logic [NBUF-1:0]  fb_we_q, fb_we_d;
    logic [ADDRW-1:0] fb_addr_write_q, fb_addr_write_d;
    logic [DATAW-1:0] fb_colr_write_q, fb_colr_write_d;

    assign free_sel   = pick_free(NBUF, 32'(disp_idx_q), 32'(ready_idx_q), ready_valid_q);
    assign free_found = free_sel < NBUF;
    assign free_idx   = free_sel[IdxW-1:0];

    // A finish is published on the render_done edge so a coincident frame can take it at once.
    assign publish = (state_q == StDraw) && render_done;

    always_comb begin
        state_d         = state_q;
        fb_we_d         = '0;
        fb_addr_write_d = draw_addr;
        fb_colr_write_d = draw_colr;
        unique case (state_q)
            StIdle: begin
                if (frame) state_d = StWait;
            end
            StWait: begin
                if (free_found) state_d = clear_en ? StClear : StDraw;
            end
            StClear: begin
                fb_we_d         = NBUF'(1) << draw_idx_q;
                fb_addr_write_d = clr_addr_q;
                fb_colr_write_d = clr_colr_q;
                if (clr_addr_q == LastAddr) state_d = StDraw;
            end
            StDraw: begin
                fb_we_d = draw_we ? (NBUF'(1) << draw_idx_q) : '0;
                if (render_done) state_d = StDone;
            end
            StDone: begin
                state_d = StWait;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            draw_idx_q      <= '0;
            disp_idx_q      <= '0;
            ready_idx_q     <= '0;
            ready_valid_q   <= 1'b0;
            clr_colr_q      <= '0;
            clr_addr_q      <= '0;
            cnt_drop_q      <= '0;
            render_start_q  <= 1'b0;
            fb_we_q         <= '0;
            fb_addr_write_q <= '0;
            fb_colr_write_q <= '0;
        end else begin
            state_q         <= state_d;
            render_start_q  <= (state_d == StDraw) && (state_q != StDraw);
            fb_we_q         <= fb_we_d;
            fb_addr_write_q <= fb_addr_write_d;
            fb_colr_write_q <= fb_colr_write_d;
            clr_addr_q      <= (state_q == StClear) ? clr_addr_q + ADDRW'(1) : '0;

            if (state_q == StWait && free_found) begin
                draw_idx_q <= free_idx;
                clr_colr_q <= clear_colr;
            end

            if (frame) begin
                if (publish) begin
                    disp_idx_q <= draw_idx_q;
                end else if (ready_valid_q) begin
                    disp_idx_q <= ready_idx_q;
                end
                ready_valid_q <= 1'b0;
            end else if (publish) begin
                ready_idx_q   <= draw_idx_q;
                ready_valid_q <= 1'b1;
            end

            // An undisplayed ready buffer superseded by a newer one counts as dropped.
            if (publish && ready_valid_q && cnt_drop_q != 8'hff) begin
                cnt_drop_q <= cnt_drop_q + 8'd1;
            end
        end
    end

    fb_read_gen #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT),
        .FB_SCALE  (FB_SCALE),
        .ADDRW     (ADDRW)
    ) u_read_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame        (frame),
        .line         (line),
        .line0        (line0),
        .lb_en_in     (lb_en_in),
        .fb_addr_read (fb_addr_read)
    );

    assign render_start  = render_start_q;
    assign fb_we         = fb_we_q;
    assign fb_addr_write = fb_addr_write_q;
    assign fb_colr_write = fb_colr_write_q;
    assign fb_rsel       = disp_idx_q;
    assign busy          = (state_q != StIdle) && (state_q != StWait);
    assign cnt_drop      = cnt_drop_q;

endmodule
